// File: rtl/axi_txn_sched_if.sv
// -----------------------------------------------------------------------------
// axi_txn_sched_if
// Bundles the requester side and the burst-engine side of axi_txn_sched.
//
// Modports:
//   master : the scheduler itself. It drives ACK/ACK_ERR/GRANT_ID/BUSY and the
//            engine command (M_INIT_AXI_TXN, M_TXN_ADDR, M_TXN_LEN).
//   slave  : the environment, i.e. the requesters plus the burst engine. It
//            drives REQ/REQ_ADDR/REQ_LEN and M_TXN_DONE/M_ERROR.
//
// Signals:
//   REQ       [NUM_REQ]        level request per requester, held until ACK
//   REQ_ADDR  [NUM_REQ*ADDR_W] flattened base addresses, slice i = requester i
//   REQ_LEN   [NUM_REQ*LEN_W]  flattened AxLEN-encoded burst lengths
//   ACK       [NUM_REQ]        one-cycle completion pulse
//   ACK_ERR                    error status, valid in the ACK cycle
//   GRANT_ID  [ID_W]           current or last granted requester
//   BUSY                       high from grant through the ACK cycle
//   M_INIT_AXI_TXN             engine start pulse
//   M_TXN_ADDR [ADDR_W]        latched base address
//   M_TXN_LEN  [LEN_W]         latched burst length
//   M_TXN_DONE                 engine completion level
//   M_ERROR                    engine error, sampled with DONE
// -----------------------------------------------------------------------------
interface axi_txn_sched_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LEN_W   = 8
);
    localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        REQ;
    logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR;
    logic [NUM_REQ*LEN_W-1:0]  REQ_LEN;
    logic [NUM_REQ-1:0]        ACK;
    logic                      ACK_ERR;
    logic [ID_W-1:0]           GRANT_ID;
    logic                      BUSY;
    logic                      M_INIT_AXI_TXN;
    logic [ADDR_W-1:0]         M_TXN_ADDR;
    logic [LEN_W-1:0]          M_TXN_LEN;
    logic                      M_TXN_DONE;
    logic                      M_ERROR;

    modport master (
        input  REQ, REQ_ADDR, REQ_LEN, M_TXN_DONE, M_ERROR,
        output ACK, ACK_ERR, GRANT_ID, BUSY, M_INIT_AXI_TXN, M_TXN_ADDR, M_TXN_LEN
    );

    modport slave (
        output REQ, REQ_ADDR, REQ_LEN, M_TXN_DONE, M_ERROR,
        input  ACK, ACK_ERR, GRANT_ID, BUSY, M_INIT_AXI_TXN, M_TXN_ADDR, M_TXN_LEN
    );
endinterface

// File: rtl/axi_txn_sched.sv
// -----------------------------------------------------------------------------
// axi_txn_sched
// Shares one AXI4 master burst engine (INIT_AXI_TXN / TXN_DONE / ERROR
// handshake) between NUM_REQ requesters. Requests are arbitrated round-robin,
// the winner's address/length are latched and handed to the engine with a
// start pulse of INIT_PULSE cycles, and on engine completion a one-cycle ACK
// plus error status is returned to the winner.
//
// Ports:
//   ACLK     in   system clock, rising edge
//   ARESET   in   asynchronous active-high reset
//   TIMEOUT  out  sticky watchdog flag (only with AXI_TXN_SCHED_TIMEOUT_EN)
//   bus      axi_txn_sched_if.master, requester and engine signals
//
// Optional feature, macro AXI_TXN_SCHED_TIMEOUT_EN:
//   A WAIT-state watchdog of TIMEOUT_CYC cycles forces completion with
//   ACK_ERR=1 and sets TIMEOUT. Undefined: WAIT lasts until the engine is done.
// -----------------------------------------------------------------------------
module axi_txn_sched #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned LEN_W       = 8,
    parameter int unsigned INIT_PULSE  = 2,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic ACLK,
    input  logic ARESET,
`ifdef AXI_TXN_SCHED_TIMEOUT_EN
    output logic TIMEOUT,
`endif
    axi_txn_sched_if.master bus
);

    localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PCNT_W = (INIT_PULSE > 1) ? $clog2(INIT_PULSE) : 1;
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || INIT_PULSE < 1 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("axi_txn_sched: parameter out of range");
    end

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWait,
        StComplete
    } state_e;

    state_e              r_state, w_state_next;
    logic [ID_W-1:0]     r_ptr, w_ptr_next;
    logic [ID_W-1:0]     r_gid, w_gid_next;
    logic [ADDR_W-1:0]   r_addr, w_addr_next;
    logic [LEN_W-1:0]    r_len, w_len_next;
    logic                r_busy, w_busy_next;
    logic                r_init, w_init_next;
    logic [NUM_REQ-1:0]  r_ack, w_ack_next;
    logic                r_ack_err, w_ack_err_next;
    logic                r_done_q;
    logic [PCNT_W-1:0]   r_pcnt, w_pcnt_next;
    // A DONE edge seen during LAUNCH is parked here until the first WAIT cycle.
    logic                r_pend, w_pend_next;
    logic                r_pend_err, w_pend_err_next;

`ifdef AXI_TXN_SCHED_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0]     r_to_cnt, w_to_cnt_next;
    logic                r_timeout, w_timeout_next;
`endif

    logic                w_done_rise;
    logic                w_found;
    logic [ID_W-1:0]     w_pick;

    // Index base+off modulo NUM_REQ; both operands are already below NUM_REQ.
    function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base,
                                               input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return ID_W'(sum);
    endfunction

    // Only a rising edge completes, so a DONE level left over from the previous
    // transaction cannot complete the next one.
    assign w_done_rise = bus.M_TXN_DONE & ~r_done_q;

    // Round-robin search starting at the pointer, wrapping past NUM_REQ-1.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!w_found && bus.REQ[rr_idx(r_ptr, k)]) begin
                w_found = 1'b1;
                w_pick  = rr_idx(r_ptr, k);
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_ptr_next      = r_ptr;
        w_gid_next      = r_gid;
        w_addr_next     = r_addr;
        w_len_next      = r_len;
        w_busy_next     = r_busy;
        w_init_next     = r_init;
        w_ack_next      = '0;
        w_ack_err_next  = r_ack_err;
        w_pcnt_next     = r_pcnt;
        w_pend_next     = r_pend;
        w_pend_err_next = r_pend_err;
`ifdef AXI_TXN_SCHED_TIMEOUT_EN
        w_to_cnt_next   = r_to_cnt;
        w_timeout_next  = r_timeout;
`endif

        unique case (r_state)
            StIdle: begin
                if (w_found) begin
                    w_gid_next   = w_pick;
                    w_addr_next  = bus.REQ_ADDR[32'(w_pick)*ADDR_W +: ADDR_W];
                    w_len_next   = bus.REQ_LEN[32'(w_pick)*LEN_W +: LEN_W];
                    w_busy_next  = 1'b1;
                    // Start pulse rises together with BUSY, one cycle after REQ.
                    w_init_next  = 1'b1;
                    w_pcnt_next  = '0;
                    w_pend_next  = 1'b0;
                    w_state_next = StLaunch;
                end
            end

            StLaunch: begin
                if (w_done_rise) begin
                    w_pend_next     = 1'b1;
                    w_pend_err_next = bus.M_ERROR;
                end
                if (r_pcnt == PCNT_W'(INIT_PULSE - 1)) begin
                    w_init_next  = 1'b0;
                    w_state_next = StWait;
`ifdef AXI_TXN_SCHED_TIMEOUT_EN
                    w_to_cnt_next = '0;
`endif
                end else begin
                    w_pcnt_next = r_pcnt + PCNT_W'(1);
                end
            end

            StWait: begin
                if (r_pend) begin
                    w_ack_err_next = r_pend_err;
                    w_ack_next     = ONE_HOT0 << r_gid;
                    w_state_next   = StComplete;
                end else if (w_done_rise) begin
                    w_ack_err_next = bus.M_ERROR;
                    w_ack_next     = ONE_HOT0 << r_gid;
                    w_state_next   = StComplete;
                end
`ifdef AXI_TXN_SCHED_TIMEOUT_EN
                // The count would reach TIMEOUT_CYC at the end of this cycle,
                // i.e. this is the last allowed WAIT cycle.
                else if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                    w_ack_err_next = 1'b1;
                    w_timeout_next = 1'b1;
                    w_ack_next     = ONE_HOT0 << r_gid;
                    w_state_next   = StComplete;
                end else begin
                    w_to_cnt_next = r_to_cnt + TO_W'(1);
                end
`endif
            end

            StComplete: begin
                // ACK is visible this cycle; BUSY drops for the following IDLE.
                w_busy_next  = 1'b0;
                w_ptr_next   = (r_gid == ID_W'(NUM_REQ - 1)) ? '0 : r_gid + ID_W'(1);
                w_state_next = StIdle;
            end

            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_ptr      <= '0;
            r_gid      <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_busy     <= 1'b0;
            r_init     <= 1'b0;
            r_ack      <= '0;
            r_ack_err  <= 1'b0;
            r_done_q   <= 1'b0;
            r_pcnt     <= '0;
            r_pend     <= 1'b0;
            r_pend_err <= 1'b0;
`ifdef AXI_TXN_SCHED_TIMEOUT_EN
            r_to_cnt   <= '0;
            r_timeout  <= 1'b0;
`endif
        end else begin
            r_ptr      <= w_ptr_next;
            r_gid      <= w_gid_next;
            r_addr     <= w_addr_next;
            r_len      <= w_len_next;
            r_busy     <= w_busy_next;
            r_init     <= w_init_next;
            r_ack      <= w_ack_next;
            r_ack_err  <= w_ack_err_next;
            r_done_q   <= bus.M_TXN_DONE;
            r_pcnt     <= w_pcnt_next;
            r_pend     <= w_pend_next;
            r_pend_err <= w_pend_err_next;
`ifdef AXI_TXN_SCHED_TIMEOUT_EN
            r_to_cnt   <= w_to_cnt_next;
            r_timeout  <= w_timeout_next;
`endif
        end
    end

    assign bus.ACK            = r_ack;
    assign bus.ACK_ERR        = r_ack_err;
    assign bus.GRANT_ID       = r_gid;
    assign bus.BUSY           = r_busy;
    assign bus.M_INIT_AXI_TXN = r_init;
    assign bus.M_TXN_ADDR     = r_addr;
    assign bus.M_TXN_LEN      = r_len;
`ifdef AXI_TXN_SCHED_TIMEOUT_EN
    assign TIMEOUT            = r_timeout;
`endif

endmodule

// File: doc/axi_txn_sched.md
Name: axi_txn_sched

Overview:
- Shares one AXI4 master burst engine between NUM_REQ requesters.
- The engine uses the INIT_AXI_TXN / TXN_DONE / ERROR handshake. This block sits between requester logic and that engine.
- It arbitrates round-robin, latches the winner's address and length, and pulses the engine start.
- It then waits for completion and returns a per-requester ack and error status.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 32, transaction base address width.
- LEN_W, 8, burst length field width (AXI AxLEN encoding).
- INIT_PULSE, 2, start pulse width in ACLK cycles (>=1).
- TIMEOUT_CYC, 1024, watchdog limit in cycles (used only with the optional feature).

Ports:
- ACLK  in  1  system clock, all logic on rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- REQ  in  NUM_REQ  level request per requester; held until its ACK.
- REQ_ADDR  in  NUM_REQ*ADDR_W  flattened base addresses; slice i belongs to requester i.
- REQ_LEN  in  NUM_REQ*LEN_W  flattened burst lengths.
- ACK  out  NUM_REQ  one-cycle completion pulse per requester.
- ACK_ERR  out  1  error status, valid in the ACK cycle.
- GRANT_ID  out  clog2(NUM_REQ)  index of the current or last granted requester.
- BUSY  out  1  high from grant until the ACK cycle inclusive.
- M_INIT_AXI_TXN  out  1  engine start pulse.
- M_TXN_ADDR  out  ADDR_W  latched base address to the engine.
- M_TXN_LEN  out  LEN_W  latched burst length to the engine.
- M_TXN_DONE  in  1  engine completion level.
- M_ERROR  in  1  engine error, sampled with DONE.

Behaviour:
- Reset values:
  - ACK=0, ACK_ERR=0, GRANT_ID=0, BUSY=0, M_INIT_AXI_TXN=0, M_TXN_ADDR=0, M_TXN_LEN=0.
  - FSM=IDLE, round-robin pointer=0.
  - done_q (registered copy of M_TXN_DONE) =0.
- Reset mid-transaction returns to IDLE immediately. No ACK is issued for the aborted transaction.
- Done edge: done_rise = M_TXN_DONE & ~done_q. Only a rising edge completes a transaction, so a level left high from a previous transaction is ignored.
- IDLE:
  - If any REQ bit is set, pick the first set bit searching upward from the pointer with wrap (pointer..NUM_REQ-1, then 0..pointer-1).
  - Same cycle: latch addr/len slice into M_TXN_ADDR/M_TXN_LEN, set GRANT_ID, set BUSY=1, go to LAUNCH.
- LAUNCH:
  - M_INIT_AXI_TXN=1 for exactly INIT_PULSE cycles, starting the cycle after the grant.
  - Then drive it 0 and go to WAIT.
- WAIT:
  - On done_rise, capture M_ERROR into ACK_ERR and go to COMPLETE.
  - If done_rise occurs during LAUNCH, it is recorded and honoured on the first WAIT cycle.
- COMPLETE (one cycle):
  - ACK[GRANT_ID]=1, BUSY=1.
  - Pointer = GRANT_ID+1, wrapping to 0 after NUM_REQ-1.
  - Go to IDLE.
- After COMPLETE, BUSY=0 for at least one cycle before the next grant.
  - Minimum request-to-INIT latency: 1 cycle.
  - Minimum back-to-back spacing: ACK then 1 IDLE cycle then grant.
- ACK_ERR holds its value until the next COMPLETE.
- Requester signals:
  - REQ dropped before grant: the request is ignored.
  - REQ dropped after grant: the transaction still completes and ACKs.
  - REQ_ADDR/REQ_LEN are only sampled at grant.
- Fairness: a requester waits at most NUM_REQ-1 other transactions.

Optional Feature:
- Macro: AXI_TXN_SCHED_TIMEOUT_EN.
- When defined:
  - A counter of clog2(TIMEOUT_CYC+1) bits clears on entry to WAIT and increments each WAIT cycle.
  - Reaching TIMEOUT_CYC forces COMPLETE with ACK_ERR=1.
  - Adds output TIMEOUT (1 bit): a sticky flag set on any timeout, cleared only by ARESET.
- When undefined: no counter, no TIMEOUT port, and WAIT lasts indefinitely.

Test Plan:
- Single request: ARESET released, REQ=0001, addr0=0x4000_0000, len0=15.
  -> Grant next cycle, M_TXN_ADDR=0x4000_0000, M_TXN_LEN=15, INIT high for 2 cycles.
  -> Engine DONE after 40 cycles gives ACK=0001 for 1 cycle, ACK_ERR=0.
- Round-robin: REQ=1111 held, each DONE returned 10 cycles after INIT.
  -> Grant order 0,1,2,3,0; every ACK pulse is 1 cycle with a BUSY low gap of at least 1 cycle.
- Error propagation: requester 2 granted, engine asserts M_ERROR=1 with DONE.
  -> ACK=0100, ACK_ERR=1; the next transaction with M_ERROR=0 gives ACK_ERR=0.
- Stale DONE: M_TXN_DONE held high from the previous transaction into the next grant.
  -> No completion until DONE falls and rises again.
- Reset mid-WAIT: assert ARESET during WAIT for requester 1.
  -> All outputs return to 0 asynchronously, no ACK is issued, and the first grant after release goes to requester 0.
- Timeout (macro defined, TIMEOUT_CYC=64): grant requester 3 and never assert DONE.
  -> ACK=1000 with ACK_ERR=1 on the 64th WAIT cycle; TIMEOUT=1 and stays high until reset.
